// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
//
// Shared definitions for the contador counter family.
//   CNT_WRAP / CNT_SAT : values for the SAT parameter of contador_mod_updown.
//                        Instances should name these rather than pass 0 / 1.
//   cnt_op_t           : the single operation selected on a clock edge, in
//                        priority order clear > load > count > hold.
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } cnt_op_t;

endpackage : contador_pkg

// File: rtl/contador_mod_updown.sv
// -----------------------------------------------------------------------------
// contador_mod_updown
//
// Parametrised synchronous up/down counter over the range 0..M-1, with
// wrap-or-saturate terminal behaviour, parallel load with clamping, cascadable
// enables (ent/enp/rco), mid-point flag, registered compare pulse and a sticky
// terminal-event flag.
//
// Parameters:
//   N    : counter width in bits.
//   M    : modulus, 2 <= M <= 2^N.
//   MEIO : value of Q that raises meio, MEIO < M.
//   SAT  : CNT_WRAP (wrap at the ends) or CNT_SAT (hold at the ends).
//
// Ports:
//   clock : rising-edge clock.
//   clr   : asynchronous active-low reset (Q, hit, ovf -> 0).
//   sclr  : synchronous active-low clear (Q, hit, ovf -> 0).
//   ld    : synchronous active-low parallel load of D (clamped to M-1).
//   ent   : count enable T; also gates rco.
//   enp   : count enable P.
//   up    : direction, 1 = up, 0 = down.
//   D     : load value.
//   cmp   : compare value for hit.
//   Q     : count.
//   rco   : ripple carry, combinational from Q, ent, up.
//   meio  : Q == MEIO, combinational.
//   hit   : one-cycle pulse after a count step lands on cmp.
//   ovf   : sticky, set on any wrap/saturate edge, cleared by clr or sclr.
// -----------------------------------------------------------------------------
module contador_mod_updown
    import contador_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 16,
    parameter int MEIO = 7,
    parameter int SAT  = CNT_WRAP
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         sclr,
    input  logic         ld,
    input  logic         ent,
    input  logic         enp,
    input  logic         up,
    input  logic [N-1:0] D,
    input  logic [N-1:0] cmp,
    output logic [N-1:0] Q,
    output logic         rco,
    output logic         meio,
    output logic         hit,
    output logic         ovf
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (M < 2 || M > (1 << N)) begin : g_bad_modulus
        $error("contador_mod_updown: M=%0d must lie in 2..2^N (N=%0d)", M, N);
    end

    if (MEIO < 0 || MEIO >= M) begin : g_bad_meio
        $error("contador_mod_updown: MEIO=%0d must be below M=%0d", MEIO, M);
    end

    if (SAT != CNT_WRAP && SAT != CNT_SAT) begin : g_bad_sat
        $error("contador_mod_updown: SAT=%0d must be CNT_WRAP or CNT_SAT", SAT);
    end

    // ------------------------------------------------------------------
    // Constants at N+1 bits: M itself is 2^N in the full-range case and
    // would not fit in N bits, so every range comparison is done one bit
    // wider.
    // ------------------------------------------------------------------
    localparam logic [N:0] M_EXT    = (N+1)'(M);
    localparam logic [N:0] TOP_EXT  = (N+1)'(M - 1);
    localparam logic [N:0] MEIO_EXT = (N+1)'(MEIO);
    localparam logic [N:0] ONE_EXT  = (N+1)'(1);
    localparam bit         SATURATE = (SAT == CNT_SAT);

    logic [N:0] q_ext;
    logic [N:0] d_ext;
    logic [N:0] cmp_ext;
    logic [N:0] q_next_ext;
    logic       at_top;
    logic       at_bot;
    logic       terminal;
    logic       count_en;
    logic       ovf_next;
    logic       hit_next;
    cnt_op_t    op;

    assign q_ext   = {1'b0, Q};
    assign d_ext   = {1'b0, D};
    assign cmp_ext = {1'b0, cmp};

    // Terminal detect depends on direction: the top end when counting up,
    // zero when counting down.
    assign at_top   = (q_ext == TOP_EXT);
    assign at_bot   = (q_ext == '0);
    assign terminal = up ? at_top : at_bot;
    assign count_en = ent & enp;

    // rco deliberately ignores enp so a cascade can be frozen through enp
    // without breaking the carry chain into the next stage.
    assign rco  = ent & terminal;
    assign meio = (q_ext == MEIO_EXT);

    // ------------------------------------------------------------------
    // Operation select, strict priority clear > load > count > hold.
    // ------------------------------------------------------------------
    always_comb begin
        if (!sclr) begin
            op = OP_CLEAR;
        end else if (!ld) begin
            op = OP_LOAD;
        end else if (count_en) begin
            op = OP_COUNT;
        end else begin
            op = OP_HOLD;
        end
    end

    // ------------------------------------------------------------------
    // Next-value mux, overflow and compare.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        q_next_ext = q_ext;
        ovf_next   = ovf;
        hit_next   = 1'b0;

        unique case (op)
            OP_CLEAR: begin
                q_next_ext = '0;
                ovf_next   = 1'b0;
            end

            OP_LOAD: begin
                // Out-of-range load values clamp to the top of the range.
                q_next_ext = (d_ext >= M_EXT) ? TOP_EXT : d_ext;
            end

            OP_COUNT: begin
                if (terminal) begin
                    ovf_next = 1'b1;
                    if (SATURATE) begin
                        q_next_ext = q_ext;
                    end else begin
                        q_next_ext = up ? '0 : TOP_EXT;
                    end
                end else begin
                    q_next_ext = up ? (q_ext + ONE_EXT) : (q_ext - ONE_EXT);
                end

                // A saturated hold is not a step, so it never hits. cmp
                // values at or above M are excluded explicitly as well.
                hit_next = !(terminal && SATURATE)
                        && (cmp_ext < M_EXT)
                        && (q_next_ext == cmp_ext);
            end

            default: begin
                // OP_HOLD: defaults already hold Q and ovf, hit drops.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            Q   <= '0;
            hit <= 1'b0;
            ovf <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            Q   <= q_next_ext[N-1:0];
            hit <= hit_next;
            ovf <= ovf_next;
        end
    end

endmodule : contador_mod_updown

// File: tb/tb_contador_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_contador_mod_updown
//
// Directed bench for contador_mod_updown. Five instances:
//   dut_a : N=4, M=16, MEIO=7, wrap
//   dut_b : N=4, M=10, MEIO=5, saturate
//   dut_c : N=4, M=10, MEIO=5, wrap
//   lo/hi : two M=16 stages cascaded through rco -> ent
// dut_a/b/c share their control inputs; each section checks only the
// instance it targets. Expected values are pushed into a scoreboard queue
// when stimulus is driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_contador_mod_updown;
    import contador_pkg::*;

    logic       clock = 1'b0;
    logic       clr;
    logic       sclr;
    logic       ld;
    logic       ent;
    logic       enp;
    logic       up;
    logic [3:0] d;
    logic [3:0] cmp;
    logic       casc_en;

    logic [3:0] q_a, q_b, q_c, q_lo, q_hi;
    logic       rco_a, rco_b, rco_c, rco_lo, rco_hi;
    logic       meio_a, meio_b, meio_c, meio_lo, meio_hi;
    logic       hit_a, hit_b, hit_c, hit_lo, hit_hi;
    logic       ovf_a, ovf_b, ovf_c, ovf_lo, ovf_hi;

    always #5 clock = ~clock;

    contador_mod_updown #(.N(4), .M(16), .MEIO(7), .SAT(CNT_WRAP)) dut_a (
        .clock(clock), .clr(clr), .sclr(sclr), .ld(ld), .ent(ent), .enp(enp),
        .up(up), .D(d), .cmp(cmp), .Q(q_a), .rco(rco_a), .meio(meio_a),
        .hit(hit_a), .ovf(ovf_a)
    );

    contador_mod_updown #(.N(4), .M(10), .MEIO(5), .SAT(CNT_SAT)) dut_b (
        .clock(clock), .clr(clr), .sclr(sclr), .ld(ld), .ent(ent), .enp(enp),
        .up(up), .D(d), .cmp(cmp), .Q(q_b), .rco(rco_b), .meio(meio_b),
        .hit(hit_b), .ovf(ovf_b)
    );

    contador_mod_updown #(.N(4), .M(10), .MEIO(5), .SAT(CNT_WRAP)) dut_c (
        .clock(clock), .clr(clr), .sclr(sclr), .ld(ld), .ent(ent), .enp(enp),
        .up(up), .D(d), .cmp(cmp), .Q(q_c), .rco(rco_c), .meio(meio_c),
        .hit(hit_c), .ovf(ovf_c)
    );

    contador_mod_updown #(.N(4), .M(16), .MEIO(7), .SAT(CNT_WRAP)) dut_lo (
        .clock(clock), .clr(clr), .sclr(1'b1), .ld(1'b1), .ent(casc_en),
        .enp(1'b1), .up(1'b1), .D(4'd0), .cmp(4'd0), .Q(q_lo), .rco(rco_lo),
        .meio(meio_lo), .hit(hit_lo), .ovf(ovf_lo)
    );

    contador_mod_updown #(.N(4), .M(16), .MEIO(7), .SAT(CNT_WRAP)) dut_hi (
        .clock(clock), .clr(clr), .sclr(1'b1), .ld(1'b1), .ent(rco_lo),
        .enp(1'b1), .up(1'b1), .D(4'd0), .cmp(4'd0), .Q(q_hi), .rco(rco_hi),
        .meio(meio_hi), .hit(hit_hi), .ovf(ovf_hi)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [7:0] value);
        exp_t e;
        e.tag = tag;
        e.exp = value;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    // Returns 1 time unit after the rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic reset_all();
        @(negedge clock);
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int mq;
        int hq;
        int moved;
        int exp_ovf;

        clr     = 1'b0;
        sclr    = 1'b1;
        ld      = 1'b1;
        ent     = 1'b0;
        enp     = 1'b0;
        up      = 1'b1;
        d       = 4'd0;
        cmp     = 4'd0;
        casc_en = 1'b0;

        // ---- 1: default free-run, 20 clocks from reset -----------------
        reset_all();
        ent = 1'b1;
        enp = 1'b1;
        up  = 1'b1;
        cmp = 4'd0;
        push("a_reset_q", 8'd0);    check(8'(q_a));
        push("a_reset_hit", 8'd0);  check(8'(hit_a));
        push("a_reset_ovf", 8'd0);  check(8'(ovf_a));
        push("a_reset_meio", 8'd0); check(8'(meio_a));
        push("a_reset_rco", 8'd0);  check(8'(rco_a));
        for (int i = 1; i <= 20; i++) begin
            mq = i % 16;
            push("a_run_q", 8'(mq));
            push("a_run_meio", 8'(mq == 7));
            push("a_run_rco", 8'(mq == 15));
            push("a_run_ovf", 8'(i >= 16));
            push("a_run_hit", 8'(i == 16));
            tick();
            check(8'(q_a));
            check(8'(meio_a));
            check(8'(rco_a));
            check(8'(ovf_a));
            check(8'(hit_a));
        end

        // ---- 2: M=10 saturate, counting down from a load of 3 ----------
        reset_all();
        ld  = 1'b0;
        d   = 4'd3;
        ent = 1'b0;
        up  = 1'b0;
        cmp = 4'd0;
        push("b_load_q", 8'd3);
        push("b_load_meio", 8'd0);
        tick();
        check(8'(q_b));
        check(8'(meio_b));
        ld      = 1'b1;
        ent     = 1'b1;
        enp     = 1'b1;
        mq      = 3;
        exp_ovf = 0;
        for (int i = 0; i < 5; i++) begin
            moved = (mq != 0) ? 1 : 0;
            if (mq == 0) exp_ovf = 1;
            else         mq      = mq - 1;
            push("b_down_q", 8'(mq));
            push("b_down_hit", 8'(moved == 1 && mq == 0));
            push("b_down_ovf", 8'(exp_ovf));
            push("b_down_rco", 8'(mq == 0));
            tick();
            check(8'(q_b));
            check(8'(hit_b));
            check(8'(ovf_b));
            check(8'(rco_b));
        end

        // ---- 3: M=10 wrap, out-of-range load then one up step ----------
        reset_all();
        ld  = 1'b0;
        d   = 4'd13;
        ent = 1'b0;
        up  = 1'b1;
        cmp = 4'd15;
        push("c_clamp_q", 8'd9);
        push("c_clamp_meio", 8'd0);
        push("c_clamp_rco", 8'd0);
        tick();
        check(8'(q_c));
        check(8'(meio_c));
        check(8'(rco_c));
        ld  = 1'b1;
        ent = 1'b1;
        enp = 1'b1;
        push("c_wrap_q", 8'd0);
        push("c_wrap_ovf", 8'd1);
        push("c_cmp_big_hit", 8'd0);
        tick();
        check(8'(q_c));
        check(8'(ovf_c));
        check(8'(hit_c));

        // ---- 4: clear beats load beats count ---------------------------
        reset_all();
        ld  = 1'b0;
        d   = 4'd15;
        ent = 1'b0;
        up  = 1'b1;
        tick();
        ld  = 1'b1;
        ent = 1'b1;
        enp = 1'b1;
        push("a_pre_q", 8'd0);
        push("a_pre_ovf", 8'd1);
        tick();
        check(8'(q_a));
        check(8'(ovf_a));
        ld  = 1'b0;
        d   = 4'd5;
        cmp = 4'd5;
        push("a_ldcnt_q", 8'd5);
        push("a_ldcnt_ovf", 8'd1);
        push("a_ldcnt_hit", 8'd0);
        tick();
        check(8'(q_a));
        check(8'(ovf_a));
        check(8'(hit_a));
        sclr = 1'b0;
        ld   = 1'b0;
        d    = 4'd9;
        push("a_sclr_q", 8'd0);
        push("a_sclr_ovf", 8'd0);
        tick();
        check(8'(q_a));
        check(8'(ovf_a));
        sclr = 1'b1;
        ld   = 1'b0;
        d    = 4'd6;
        ent  = 1'b0;
        push("a_load6_q", 8'd6);
        tick();
        check(8'(q_a));

        // ---- 5: async clr mid-count, compare pulse ---------------------
        reset_all();
        cmp = 4'd4;
        ld  = 1'b0;
        d   = 4'd15;
        ent = 1'b0;
        tick();
        ld  = 1'b1;
        ent = 1'b1;
        enp = 1'b1;
        up  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        push("a_at4_q", 8'd4);
        push("a_at4_hit", 8'd1);
        push("a_at4_ovf", 8'd1);
        check(8'(q_a));
        check(8'(hit_a));
        check(8'(ovf_a));
        #2;
        clr = 1'b0;
        #1;
        push("a_clr_q", 8'd0);
        push("a_clr_hit", 8'd0);
        push("a_clr_ovf", 8'd0);
        check(8'(q_a));
        check(8'(hit_a));
        check(8'(ovf_a));
        #1;
        clr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push("a_resume_q", 8'(i));
            push("a_resume_hit", 8'(i == 4));
            tick();
            check(8'(q_a));
            check(8'(hit_a));
        end

        // ---- 6: two-stage cascade, 256 clocks --------------------------
        reset_all();
        ent     = 1'b0;
        casc_en = 1'b1;
        hq      = 0;
        for (int i = 1; i <= 256; i++) begin
            // Upper stage steps only when the lower stage leaves 15.
            if ((i % 16) == 0) hq = (hq + 1) % 16;
            push("casc_value", 8'(hq * 16 + (i % 16)));
            push("casc_rco_lo", 8'((i % 16) == 15));
            tick();
            check({q_hi, q_lo});
            check(8'(rco_lo));
        end
        push("casc_ovf_lo", 8'd1);
        push("casc_ovf_hi", 8'd1);
        push("casc_hit_lo", 8'd1);
        push("casc_hit_hi", 8'd1);
        push("casc_rco_hi", 8'd0);
        push("casc_meio_lo", 8'd0);
        push("casc_meio_hi", 8'd0);
        check(8'(ovf_lo));
        check(8'(ovf_hi));
        check(8'(hit_lo));
        check(8'(hit_hi));
        check(8'(rco_hi));
        check(8'(meio_lo));
        check(8'(meio_hi));
        casc_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_contador_mod_updown
